// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode with bypassed 32x32 register file,
//               immediate extension and load-use stall detection.
// Revision    : 1.0
// ============================================================================
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] ins_in,
    input  logic        ins_valid,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall_out,
    output logic        de_valid,
    output logic [6:0]  de_opcode,
    output logic [4:0]  de_dst,
    output logic [31:0] de_ra,
    output logic [31:0] de_rb,
    output logic [31:0] de_imm,
    output logic        de_we,
    output logic        de_is_load,
    output logic        de_is_store,
    output logic        de_is_branch,
    output logic        de_illegal
);

    localparam logic [6:0] c_OP_ADD  = 7'h00;
    localparam logic [6:0] c_OP_SUB  = 7'h01;
    localparam logic [6:0] c_OP_MUL  = 7'h02;
    localparam logic [6:0] c_OP_LDB  = 7'h10;
    localparam logic [6:0] c_OP_LDW  = 7'h11;
    localparam logic [6:0] c_OP_STB  = 7'h12;
    localparam logic [6:0] c_OP_STW  = 7'h13;
    localparam logic [6:0] c_OP_BEQ  = 7'h30;
    localparam logic [6:0] c_OP_JUMP = 7'h31;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [4:0]  dst;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] imm;
        logic        we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        illegal;
    } de_t;

    de_t         de_q, de_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_dst_f, w_src1, w_src2, w_idx2;
    logic        w_use1, w_use2;
    logic [4:0]  w_dst;
    logic [31:0] w_imm;
    logic        w_we, w_ld, w_st, w_br, w_ill;
    logic [31:0] w_rd1, w_rd2;
    logic        w_hazard;

    assign w_opcode = ins_in[31:25];
    assign w_dst_f  = ins_in[24:20];
    assign w_src1   = ins_in[19:15];
    assign w_src2   = ins_in[14:10];

    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_idx2 = w_src2;
        w_dst  = '0;
        w_imm  = '0;
        w_we   = 1'b0;
        w_ld   = 1'b0;
        w_st   = 1'b0;
        w_br   = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_MUL: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_dst  = w_dst_f;
                w_imm  = {{22{ins_in[9]}}, ins_in[9:0]};
                w_we   = 1'b1;
            end
            c_OP_LDB, c_OP_LDW: begin
                w_use1 = 1'b1;
                w_dst  = w_dst_f;
                w_imm  = {{17{ins_in[14]}}, ins_in[14:0]};
                w_we   = 1'b1;
                w_ld   = 1'b1;
            end
            c_OP_STB, c_OP_STW: begin
                // Store data register lives in the destination field
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_idx2 = w_dst_f;
                w_imm  = {{17{ins_in[14]}}, ins_in[14:0]};
                w_st   = 1'b1;
            end
            c_OP_BEQ: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_imm  = {{17{ins_in[24]}}, ins_in[24:20], ins_in[9:0]};
                w_br   = 1'b1;
            end
            c_OP_JUMP: begin
                w_imm  = {{17{ins_in[24]}}, ins_in[24:20], ins_in[9:0]};
                w_br   = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_use1 && (w_src1 != 5'd0)) begin
            w_rd1 = (wb_en && (wb_addr == w_src1)) ? wb_data : rf_q[w_src1];
        end
        if (w_use2 && (w_idx2 != 5'd0)) begin
            w_rd2 = (wb_en && (wb_addr == w_idx2)) ? wb_data : rf_q[w_idx2];
        end
    end

    assign w_hazard  = (w_use1 && (w_src1 == de_q.dst)) || (w_use2 && (w_idx2 == de_q.dst));
    assign stall_out = ins_valid & de_q.valid & de_q.is_load & (de_q.dst != 5'd0)
                     & w_hazard & ~flush;

    always_comb begin
        de_d = de_q;
        if (enable) begin
            de_d = '0;
            if (!flush && !stall_out && ins_valid) begin
                de_d.valid     = 1'b1;
                de_d.opcode    = w_opcode;
                de_d.dst       = w_dst;
                de_d.ra        = w_rd1;
                de_d.rb        = w_rd2;
                de_d.imm       = w_imm;
                de_d.we        = w_we;
                de_d.is_load   = w_ld;
                de_d.is_store  = w_st;
                de_d.is_branch = w_br;
                de_d.illegal   = w_ill;
            end
        end
    end

    // Register file writes are independent of the pipeline enable
    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 5'd0)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            de_q <= de_d;
            rf_q <= rf_d;
        end
    end

    assign de_valid     = de_q.valid;
    assign de_opcode    = de_q.opcode;
    assign de_dst       = de_q.dst;
    assign de_ra        = de_q.ra;
    assign de_rb        = de_q.rb;
    assign de_imm       = de_q.imm;
    assign de_we        = de_q.we;
    assign de_is_load   = de_q.is_load;
    assign de_is_store  = de_q.is_store;
    assign de_is_branch = de_q.is_branch;
    assign de_illegal   = de_q.illegal;

endmodule
`default_nettype wire
